// File: rtl/rain_drop_engine_if.sv
// rain_drop_engine_if: valid/ready pixel stream from the raindrop engine to the VGA pixel path.
interface rain_drop_engine_if;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_x;
    logic [7:0] pix_y;
    logic [2:0] pix_colour;

    modport master (output pix_valid, output pix_x, output pix_y, output pix_colour,
                    input  pix_ready);
    modport slave  (input  pix_valid, input  pix_x, input  pix_y, input  pix_colour,
                    output pix_ready);
endinterface

// File: rtl/rain_drop_engine.sv
// rain_drop_engine: spawns, erases, moves and redraws falling 1x2 raindrops once per frame tick.
// Optional feature macro RAIN_SPEEDUP_EN: halve the spawn period after every 16 successful spawns.
module rain_drop_engine #(
    parameter int unsigned N_DROPS      = 8,
    parameter int unsigned SPAWN_PERIOD = 4,
    parameter int unsigned PLAYER_Y     = 110,
    parameter logic [2:0]  DROP_COLOUR  = 3'b001
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      frame_tick,
    input  logic [7:0]                p1_x,
    input  logic [7:0]                p2_x,
    rain_drop_engine_if.master        pix,
    output logic                      hit_p1,
    output logic                      hit_p2,
    output logic                      busy
);
    localparam int unsigned IW = (N_DROPS > 1) ? $clog2(N_DROPS) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_DROPS - 1);
    localparam logic [7:0]    PY   = 8'(PLAYER_Y);

    typedef enum logic [2:0] {
        S_IDLE, S_SPAWN, S_ERASE0, S_ERASE1, S_MOVE, S_DRAW0, S_DRAW1, S_NEXT
    } state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic [N_DROPS-1:0] act;
    logic [7:0]         dx [N_DROPS];
    logic [7:0]         dy [N_DROPS];
    logic [15:0]        lfsr;
    logic [7:0]         spawn_cnt;
    logic [7:0]         eff_period;
    logic               pending;
    logic               fresh_vld;
    logic [IW-1:0]      fresh_idx;

    logic               free_found;
    logic [IW-1:0]      free_idx;
    logic [7:0]         fold_x;
    logic [IW-1:0]      nidx;
    logic [7:0]         cur_x;
    logic [7:0]         ny;
    logic               hit1;
    logic               hit2;
    logic [7:0]         cnt_inc;
    logic               spawn_due;

`ifdef RAIN_SPEEDUP_EN
    logic [3:0]         spawn_total;
`else
    assign eff_period = 8'(SPAWN_PERIOD);
`endif

    // Lowest-index free slot for the next spawn.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = int'(N_DROPS) - 1; i >= 0; i--) begin
            if (!act[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    // LFSR columns above 158 fold back into the visible 160-column range.
    assign fold_x    = (lfsr[7:0] > 8'd158) ? (lfsr[7:0] - 8'd128) : lfsr[7:0];
    assign nidx      = idx + IW'(1);
    assign cur_x     = dx[idx];
    assign ny        = dy[idx] + 8'd1;
    assign hit1      = ((ny + 8'd1) >= PY) && ((cur_x == p1_x) || (cur_x == (p1_x + 8'd1)));
    assign hit2      = ((ny + 8'd1) >= PY) && ((cur_x == p2_x) || (cur_x == (p2_x + 8'd1)));
    assign cnt_inc   = spawn_cnt + 8'd1;
    assign spawn_due = (cnt_inc >= eff_period);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= S_IDLE;
            idx            <= '0;
            act            <= '0;
            lfsr           <= 16'hACE1;
            spawn_cnt      <= 8'd0;
            pending        <= 1'b0;
            fresh_vld      <= 1'b0;
            fresh_idx      <= '0;
            busy           <= 1'b0;
            hit_p1         <= 1'b0;
            hit_p2         <= 1'b0;
            pix.pix_valid  <= 1'b0;
            pix.pix_x      <= 8'd0;
            pix.pix_y      <= 8'd0;
            pix.pix_colour <= 3'b000;
            for (int i = 0; i < int'(N_DROPS); i++) begin
                dx[i] <= 8'd0;
                dy[i] <= 8'd0;
            end
`ifdef RAIN_SPEEDUP_EN
            spawn_total    <= 4'd0;
            eff_period     <= 8'(SPAWN_PERIOD);
`endif
        end else begin
            lfsr   <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            hit_p1 <= 1'b0;
            hit_p2 <= 1'b0;
            if (frame_tick && (state != S_IDLE)) pending <= 1'b1;

            unique case (state)
                S_IDLE: begin
                    if (frame_tick || pending) begin
                        state   <= S_SPAWN;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                    end
                end
                S_SPAWN: begin
                    idx       <= '0;
                    fresh_vld <= 1'b0;
                    if (spawn_due) begin
                        spawn_cnt <= 8'd0;
                        if (free_found) begin
                            act[free_idx] <= 1'b1;
                            dx[free_idx]  <= fold_x;
                            dy[free_idx]  <= 8'd0;
                            fresh_vld     <= 1'b1;
                            fresh_idx     <= free_idx;
`ifdef RAIN_SPEEDUP_EN
                            spawn_total <= spawn_total + 4'd1;
                            if (spawn_total == 4'hF)
                                eff_period <= (eff_period > 8'd1) ? (eff_period >> 1) : 8'd1;
`endif
                        end
                    end else begin
                        spawn_cnt <= cnt_inc;
                    end
                    // Slot 0 dispatch: a drop spawned right now is drawn without a move.
                    if (spawn_due && free_found && (free_idx == '0)) begin
                        state          <= S_DRAW0;
                        pix.pix_valid  <= 1'b1;
                        pix.pix_x      <= fold_x;
                        pix.pix_y      <= 8'd0;
                        pix.pix_colour <= DROP_COLOUR;
                    end else if (act[0]) begin
                        state          <= S_ERASE0;
                        pix.pix_valid  <= 1'b1;
                        pix.pix_x      <= dx[0];
                        pix.pix_y      <= dy[0];
                        pix.pix_colour <= 3'b000;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_ERASE0: begin
                    if (pix.pix_ready) begin
                        pix.pix_y <= pix.pix_y + 8'd1;
                        state     <= S_ERASE1;
                    end
                end
                S_ERASE1: begin
                    if (pix.pix_ready) begin
                        pix.pix_valid <= 1'b0;
                        state         <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (hit1 || hit2) begin
                        act[idx] <= 1'b0;
                        hit_p1   <= hit1;
                        hit_p2   <= hit2;
                        state    <= S_NEXT;
                    end else if (ny > 8'd118) begin
                        act[idx] <= 1'b0;
                        state    <= S_NEXT;
                    end else begin
                        dy[idx]        <= ny;
                        state          <= S_DRAW0;
                        pix.pix_valid  <= 1'b1;
                        pix.pix_x      <= cur_x;
                        pix.pix_y      <= ny;
                        pix.pix_colour <= DROP_COLOUR;
                    end
                end
                S_DRAW0: begin
                    if (pix.pix_ready) begin
                        pix.pix_y <= pix.pix_y + 8'd1;
                        state     <= S_DRAW1;
                    end
                end
                S_DRAW1: begin
                    if (pix.pix_ready) begin
                        pix.pix_valid <= 1'b0;
                        state         <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (idx == LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        idx <= nidx;
                        if (fresh_vld && (fresh_idx == nidx)) begin
                            state          <= S_DRAW0;
                            pix.pix_valid  <= 1'b1;
                            pix.pix_x      <= dx[nidx];
                            pix.pix_y      <= dy[nidx];
                            pix.pix_colour <= DROP_COLOUR;
                        end else if (act[nidx]) begin
                            state          <= S_ERASE0;
                            pix.pix_valid  <= 1'b1;
                            pix.pix_x      <= dx[nidx];
                            pix.pix_y      <= dy[nidx];
                            pix.pix_colour <= 3'b000;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rain_drop_engine.sv
// tb_rain_drop_engine: directed vectors plus randomized frames checked against a drop-list model.
module tb_rain_drop_engine;
    localparam int unsigned N      = 4;
    localparam int unsigned PERIOD = 1;
    localparam int unsigned PY     = 110;
    localparam logic [2:0]  COL    = 3'b001;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       frame_tick = 1'b0;
    logic [7:0] p1_x = 8'd0;
    logic [7:0] p2_x = 8'd0;
    logic       hit_p1, hit_p2, busy;

    rain_drop_engine_if pif ();

    rain_drop_engine #(
        .N_DROPS(N), .SPAWN_PERIOD(PERIOD), .PLAYER_Y(PY), .DROP_COLOUR(COL)
    ) dut (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
        .p1_x(p1_x), .p2_x(p2_x), .pix(pif),
        .hit_p1(hit_p1), .hit_p2(hit_p2), .busy(busy)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        int extra_ticks;
        int stall;
        int exp_sweeps;
    } vec_t;

    int compared = 0;
    int mismatched = 0;

    // Reference model: list of drops, spawn counter, expected pixel stream and hits.
    logic       m_act [N];
    logic [7:0] m_x [N];
    logic [7:0] m_y [N];
    int         m_cnt = 0;
    logic [15:0] m_lfsr;
    pix_t       exp_q [$];
    int exp_h1 = 0, exp_h2 = 0, got_h1 = 0, got_h2 = 0;
    int total_h1 = 0, total_h2 = 0;
    int sweeps = 0, frame_pix = 0, last_frame_pix = 0;
    bit prev_busy = 1'b0;
    bit snap_vld = 1'b0;
    pix_t snap;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) m_lfsr <= 16'hACE1;
        else         m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    task automatic model_frame();
        int fresh;
        logic [7:0] fx, ny;
        bit h1, h2;
        fresh = -1;
        m_cnt++;
        if (m_cnt >= int'(PERIOD)) begin
            m_cnt = 0;
            for (int i = N - 1; i >= 0; i--) if (!m_act[i]) fresh = i;
            if (fresh >= 0) begin
                fx = m_lfsr[7:0];
                if (fx > 8'd158) fx = fx - 8'd128;
                m_act[fresh] = 1'b1;
                m_x[fresh] = fx;
                m_y[fresh] = 8'd0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (m_act[i] && i == fresh) begin
                exp_q.push_back('{m_x[i], 8'd0, COL});
                exp_q.push_back('{m_x[i], 8'd1, COL});
            end else if (m_act[i]) begin
                exp_q.push_back('{m_x[i], m_y[i], 3'b000});
                exp_q.push_back('{m_x[i], 8'(m_y[i] + 8'd1), 3'b000});
                ny = m_y[i] + 8'd1;
                h1 = (int'(ny) + 1 >= int'(PY)) && (m_x[i] == p1_x || m_x[i] == 8'(p1_x + 8'd1));
                h2 = (int'(ny) + 1 >= int'(PY)) && (m_x[i] == p2_x || m_x[i] == 8'(p2_x + 8'd1));
                if (h1 || h2) begin
                    m_act[i] = 1'b0;
                    if (h1) exp_h1++;
                    if (h2) exp_h2++;
                end else if (ny > 8'd118) begin
                    m_act[i] = 1'b0;
                end else begin
                    m_y[i] = ny;
                    exp_q.push_back('{m_x[i], ny, COL});
                    exp_q.push_back('{m_x[i], 8'(ny + 8'd1), COL});
                end
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        pix_t got, e;
        got = '{pif.pix_x, pif.pix_y, pif.pix_colour};
        if (!resetn) begin
            for (int i = 0; i < N; i++) m_act[i] = 1'b0;
            m_cnt = 0; exp_q.delete();
            exp_h1 = 0; exp_h2 = 0; got_h1 = 0; got_h2 = 0;
            frame_pix = 0; prev_busy = 1'b0; snap_vld = 1'b0;
        end else begin
            if (snap_vld) begin
                check("stall_hold", {pif.pix_valid, got}, {1'b1, snap});
                snap_vld = 1'b0;
            end
            if (busy && !prev_busy) begin
                sweeps++;
                model_frame();
            end
            if (!busy) check("valid_when_idle", pif.pix_valid, 0);
            if (pif.pix_valid) begin
                if (pif.pix_ready) begin
                    frame_pix++;
                    if (exp_q.size() == 0) check("pix_unexpected", got, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("pix_word", got, e);
                    end
                end else begin
                    snap = got;
                    snap_vld = 1'b1;
                end
            end
            if (hit_p1) begin got_h1++; total_h1++; end
            if (hit_p2) begin got_h2++; total_h2++; end
            if (!busy && prev_busy) begin
                check("pix_missing", exp_q.size(), 0);
                check("hit_p1_count", got_h1, exp_h1);
                check("hit_p2_count", got_h2, exp_h2);
                exp_q.delete();
                exp_h1 = 0; exp_h2 = 0; got_h1 = 0; got_h2 = 0;
                last_frame_pix = frame_pix;
                frame_pix = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) pif.pix_ready = ($urandom_range(3) != 0);
        end
    end

    task automatic tick();
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet, n;
        quiet = 0; n = 0;
        while (quiet < 3 && n < 5000) begin
            @(negedge clk);
            n++;
            if (!busy) quiet++; else quiet = 0;
        end
        if (quiet < 3) check("sweep_done", busy, 0);
    endtask

    initial begin
        vec_t vecs [6];
        int s0, best, n, r;
        bit found;
        vecs[0] = '{0, 0, 1};
        vecs[1] = '{1, 0, 2};
        vecs[2] = '{2, 0, 2};
        vecs[3] = '{3, 5, 2};
        vecs[4] = '{0, 5, 1};
        vecs[5] = '{2, 5, 2};

        pif.pix_ready = 1'b1;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", pif.pix_valid, 0);
        check("rst_xy", {pif.pix_x, pif.pix_y, pif.pix_colour}, 0);
        check("rst_hits", {hit_p1, hit_p2}, 0);
        @(posedge clk); #1 resetn = 1'b1;
        repeat (5) @(posedge clk);

        // First tick: one fresh drop at y=0, two draw pixels.
        tick(); wait_idle();
        check("t1_pixels", last_frame_pix, 2);
        check("t1_busy", busy, 0);
        // Second tick: erase, move, draw of drop 0 plus a new spawn.
        tick(); wait_idle();
        check("t2_pixels", last_frame_pix, 6);

        // Table: extra ticks during a sweep and mid-DRAW stalls.
        for (int v = 0; v < 6; v++) begin
            s0 = sweeps;
            tick();
            for (int k = 0; k < vecs[v].extra_ticks; k++) begin
                #1 frame_tick = 1'b1;
                @(posedge clk); #1 frame_tick = 1'b0;
            end
            if (vecs[v].stall > 0) begin
                found = 1'b0; n = 0;
                while (!found && n < 2000) begin
                    @(negedge clk); n++;
                    if (pif.pix_valid && pif.pix_colour == COL) found = 1'b1;
                end
                check("stall_draw_seen", found, 1);
                @(posedge clk); #1 pif.pix_ready = 1'b0;
                repeat (vecs[v].stall) @(posedge clk);
                #1 pif.pix_ready = 1'b1;
            end
            wait_idle();
            check("vec_sweeps", sweeps - s0, vecs[v].exp_sweeps);
        end

        // Randomized frames with players steered toward the lowest drop now and then.
        rand_ready = 1'b1;
        for (int f = 0; f < 400; f++) begin
            best = -1;
            for (int i = 0; i < N; i++)
                if (m_act[i] && (best < 0 || m_y[i] > m_y[best])) best = i;
            r = $urandom_range(7);
            p1_x = 8'($urandom_range(158));
            p2_x = 8'($urandom_range(158));
            if (best >= 0 && (r == 0 || r == 2)) p1_x = m_x[best] - 8'($urandom_range(1));
            if (best >= 0 && (r == 1 || r == 2)) p2_x = m_x[best] - 8'($urandom_range(1));
            tick(); wait_idle();
        end
        rand_ready = 1'b0;
        @(posedge clk); #1 pif.pix_ready = 1'b1;
        check("hits_seen_p1", total_h1 > 0, 1);
        check("hits_seen_p2", total_h2 > 0, 1);

        // Reset mid-sweep returns straight to the reset state.
        tick();
        repeat (4) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", pif.pix_valid, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 resetn = 1'b1;
        tick(); wait_idle();
        check("midrst_pixels", last_frame_pix, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
